// File: rtl/regfile_hilo_pkg.sv
// Shared widths and HI/LO write-select encoding for the WB->RF architectural state sink.
package regfile_hilo_pkg;

    localparam int WB_TO_RF_BUS_W = 105;
    localparam int RF_DW          = 32;
    localparam int RF_AW          = 5;
    localparam int HL_DW          = 64;

    typedef enum logic [1:0] {
        HL_NONE = 2'b00,
        HL_LO   = 2'b01,
        HL_HI   = 2'b10,
        HL_BOTH = 2'b11
    } hl_sel_e;

    function automatic logic hl_sel_hi(input logic [1:0] sel);
        return (sel == HL_HI) || (sel == HL_BOTH);
    endfunction

    function automatic logic hl_sel_lo(input logic [1:0] sel);
        return (sel == HL_LO) || (sel == HL_BOTH);
    endfunction

endpackage

// File: rtl/regfile_hilo_hilo.sv
// HI/LO pair: decodes the half-select, stores on posedge, combinational read with optional write-through.
// Latency 1 cycle to storage, 0 cycles through the bypass; never stalls.
module hilo_reg
    import regfile_hilo_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 hl_we_i,
    input  logic [1:0]           hl_waddr_i,
    input  logic [HL_DW-1:0]     hl_wdata_i,
    output logic [RF_DW-1:0]     hi_rdata_o,
    output logic [RF_DW-1:0]     lo_rdata_o
);

    logic [RF_DW-1:0] hi_q, hi_d;
    logic [RF_DW-1:0] lo_q, lo_d;
    logic             hi_wr, lo_wr;

    always_comb begin
        hi_wr = hl_we_i && hl_sel_hi(hl_waddr_i);
        lo_wr = hl_we_i && hl_sel_lo(hl_waddr_i);
        hi_d  = hi_wr ? hl_wdata_i[63:32] : hi_q;
        lo_d  = lo_wr ? hl_wdata_i[31:0]  : lo_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // Reads are forced to zero while reset is asserted so no stale or X value escapes.
    always_comb begin
        hi_rdata_o = '0;
        lo_rdata_o = '0;
        if (resetn) begin
            hi_rdata_o = (BYPASS && hi_wr) ? hl_wdata_i[63:32] : hi_q;
            lo_rdata_o = (BYPASS && lo_wr) ? hl_wdata_i[31:0]  : lo_q;
        end
    end

endmodule

// File: rtl/regfile_hilo.sv
// 32x32 GPR file plus HI/LO, written from the WB bus; two GPR read ports and a HI/LO read port.
// Latency 1 cycle to storage, 0 cycles through same-cycle bypass; no backpressure, every beat is consumed.
module regfile_hilo
    import regfile_hilo_pkg::*;
#(
    parameter int WB_TO_RF_WD = WB_TO_RF_BUS_W,
    parameter bit BYPASS      = 1'b1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [RF_AW-1:0]       raddr1,
    output logic [RF_DW-1:0]       rdata1,
    input  logic [RF_AW-1:0]       raddr2,
    output logic [RF_DW-1:0]       rdata2,
    output logic [RF_DW-1:0]       hi_rdata,
    output logic [RF_DW-1:0]       lo_rdata
);

    logic [HL_DW-1:0] hl_wdata;
    logic [1:0]       hl_waddr;
    logic             hl_we;
    logic             rf_we;
    logic [RF_AW-1:0] rf_waddr;
    logic [RF_DW-1:0] rf_wdata;

    assign {hl_wdata, hl_waddr, hl_we, rf_we, rf_waddr, rf_wdata} = wb_to_rf_bus;

    logic [RF_DW-1:0] gpr_q [32];
    logic             rf_wr;

    // r0 is hard-wired: it is never written and never bypassed.
    assign rf_wr = rf_we && (rf_waddr != '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (rf_wr) begin
            gpr_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (resetn && (raddr1 != '0)) begin
            rdata1 = (BYPASS && rf_wr && (raddr1 == rf_waddr)) ? rf_wdata : gpr_q[raddr1];
        end
        if (resetn && (raddr2 != '0)) begin
            rdata2 = (BYPASS && rf_wr && (raddr2 == rf_waddr)) ? rf_wdata : gpr_q[raddr2];
        end
    end

    hilo_reg #(
        .BYPASS (BYPASS)
    ) u_hilo (
        .clk        (clk),
        .resetn     (resetn),
        .hl_we_i    (hl_we),
        .hl_waddr_i (hl_waddr),
        .hl_wdata_i (hl_wdata),
        .hi_rdata_o (hi_rdata),
        .lo_rdata_o (lo_rdata)
    );

endmodule

// File: tb/tb_regfile_hilo.sv
// Self-checking bench for regfile_hilo: directed vector table, randomized run against a reference model,
// and a reset-after-random-writes sweep of r1..r31.
module tb_regfile_hilo;

    logic        clk = 1'b0;
    logic        resetn;
    logic [104:0] wb_to_rf_bus;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2, hi_rdata, lo_rdata;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hl_we;
    logic [1:0]  hl_waddr;
    logic [63:0] hl_wdata;

    int checks = 0;
    int errors = 0;

    assign wb_to_rf_bus = {hl_wdata, hl_waddr, hl_we, rf_we, rf_waddr, rf_wdata};

    always #5 clk = ~clk;

    regfile_hilo #(
        .WB_TO_RF_WD (105),
        .BYPASS      (1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .wb_to_rf_bus (wb_to_rf_bus),
        .raddr1       (raddr1),
        .rdata1       (rdata1),
        .raddr2       (raddr2),
        .rdata2       (rdata2),
        .hi_rdata     (hi_rdata),
        .lo_rdata     (lo_rdata)
    );

    typedef struct {
        logic        rstn;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hl_we;
        logic [1:0]  hl_waddr;
        logic [63:0] hl_wdata;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vt [16];

    // Reference state for the randomized run.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later, well before the next rising edge.
    task automatic drive(input logic rstn, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic hwe, input logic [1:0] hwa, input logic [63:0] hwd,
                         input logic [4:0] a1, input logic [4:0] a2);
        @(negedge clk);
        resetn   = rstn;
        rf_we    = we;
        rf_waddr = wa;
        rf_wdata = wd;
        hl_we    = hwe;
        hl_waddr = hwa;
        hl_wdata = hwd;
        raddr1   = a1;
        raddr2   = a2;
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (!resetn || a == 5'd0) return 32'h0;
        if (rf_we && rf_waddr == a) return rf_wdata;
        return m_gpr[a];
    endfunction

    function automatic logic writes_hi(input logic we, input logic [1:0] sel);
        return we && (sel == 2'b10 || sel == 2'b11);
    endfunction

    function automatic logic writes_lo(input logic we, input logic [1:0] sel);
        return we && (sel == 2'b01 || sel == 2'b11);
    endfunction

    task automatic model_commit();
        if (!resetn) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (rf_we && rf_waddr != 5'd0) m_gpr[rf_waddr] = rf_wdata;
            if (writes_hi(hl_we, hl_waddr)) m_hi = hl_wdata[63:32];
            if (writes_lo(hl_we, hl_waddr)) m_lo = hl_wdata[31:0];
        end
    endtask

    initial begin
        resetn = 1'b0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
        hl_we = 1'b0; hl_waddr = '0; hl_wdata = '0; raddr1 = '0; raddr2 = '0;

        //          rstn we  wa     wdata          hwe   hwa    hl_wdata                 ra1    ra2    e1             e2             ehi            elo
        vt[0]  = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[1]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd5,  5'd6,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[2]  = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 2'b00, 64'h0,                   5'd5,  5'd6,  32'hDEADBEEF,  32'h0,         32'h0,         32'h0};
        vt[3]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd5,  5'd5,  32'hDEADBEEF,  32'hDEADBEEF,  32'h0,         32'h0};
        vt[4]  = '{1'b1, 1'b1, 5'd0, 32'h12345678, 1'b0, 2'b00, 64'h0,                   5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd0,  5'd0,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[6]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2'b01, 64'hAAAA_AAAA_5555_5555, 5'd5,  5'd0,  32'hDEADBEEF,  32'h0,         32'h0,         32'h5555_5555};
        vt[7]  = '{1'b1, 1'b1, 5'd3, 32'h00000077, 1'b1, 2'b11, 64'h1111_1111_2222_2222, 5'd3,  5'd5,  32'h00000077,  32'hDEADBEEF,  32'h1111_1111,  32'h2222_2222};
        vt[8]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd3,  5'd3,  32'h00000077,  32'h00000077,  32'h1111_1111,  32'h2222_2222};
        vt[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd0,  5'd3,  32'h0,         32'h00000077,  32'h1111_1111,  32'h2222_2222};
        vt[10] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2'b10, 64'h3333_3333_4444_4444, 5'd3,  5'd3,  32'h00000077,  32'h00000077,  32'h3333_3333,  32'h2222_2222};
        vt[11] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 2'b00, 64'h9999_9999_9999_9999, 5'd3,  5'd0,  32'h00000077,  32'h0,         32'h3333_3333,  32'h2222_2222};
        vt[12] = '{1'b0, 1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 2'b11, 64'h5A5A_5A5A_A5A5_A5A5, 5'd7,  5'd3,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[13] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd7,  5'd3,  32'h0,         32'h0,         32'h0,         32'h0};
        vt[14] = '{1'b1, 1'b1, 5'd9, 32'hABCD0123, 1'b0, 2'b00, 64'h0,                   5'd9,  5'd9,  32'hABCD0123,  32'hABCD0123,  32'h0,         32'h0};
        vt[15] = '{1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 2'b00, 64'h0,                   5'd9,  5'd7,  32'hABCD0123,  32'h0,         32'h0,         32'h0};

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].rstn, vt[i].rf_we, vt[i].waddr, vt[i].wdata, vt[i].hl_we, vt[i].hl_waddr,
                  vt[i].hl_wdata, vt[i].ra1, vt[i].ra2);
            chk("vec_rdata1", i, rdata1, vt[i].e1);
            chk("vec_rdata2", i, rdata2, vt[i].e2);
            chk("vec_hi", i, hi_rdata, vt[i].ehi);
            chk("vec_lo", i, lo_rdata, vt[i].elo);
        end

        // Randomized run; first cycle resets so the model and DUT start from the same state.
        for (int i = 0; i < 400; i++) begin
            logic        rs;
            logic [4:0]  wa, a1, a2;
            rs = (i == 0) ? 1'b0 : ($urandom_range(0, 24) != 0);
            wa = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            a1 = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 3));
            drive(rs, 1'($urandom_range(0, 1)), wa, $urandom, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), {$urandom, $urandom}, a1, a2);
            chk("rnd_rdata1", i, rdata1, model_rd(raddr1));
            chk("rnd_rdata2", i, rdata2, model_rd(raddr2));
            chk("rnd_hi", i, hi_rdata, !resetn ? 32'h0 : (writes_hi(hl_we, hl_waddr) ? hl_wdata[63:32] : m_hi));
            chk("rnd_lo", i, lo_rdata, !resetn ? 32'h0 : (writes_lo(hl_we, hl_waddr) ? hl_wdata[31:0] : m_lo));
            model_commit();
        end

        // Fill every register with nonzero data, reset, then confirm r1..r31 and HI/LO all read 0.
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 1'b1, 5'(r), $urandom | 32'h1, 1'b1, 2'b11, {$urandom | 32'h1, $urandom | 32'h1}, 5'd0, 5'd0);
        end
        drive(1'b0, 1'b1, 5'd12, 32'hFFFF_0000, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd12, 5'd1);
        for (int r = 1; r < 32; r++) begin
            drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 2'b00, 64'h0, 5'(r), 5'(32 - r));
            chk("rst_rdata1", r, rdata1, 32'h0);
            chk("rst_rdata2", r, rdata2, 32'h0);
            chk("rst_hi", r, hi_rdata, 32'h0);
            chk("rst_lo", r, lo_rdata, 32'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
